m_phy_lane_10b8b_dec: RTL and testbench
=======================================

Name: m_phy_lane_10b8b_dec

Overview:
Per-lane 8b/10b decoder and link-quality monitor. It sits directly downstream of the lane serial-to-parallel/comma-aligner stage. It consumes aligned 10-bit symbols and produces bytes plus K-flags, tracking running disparity. On excessive code or disparity errors it pulses unlock back to the aligner and waits for re-alignment.

Parameters:
WINDOW, 256, error-monitor window length in valid symbols (2..65535)
ERR_THRESH, 4, errors within one window that trigger unlock (1..WINDOW)
CNT_W, 16, width of the saturating lifetime error counter

Ports:
clk  input  1  lane symbol clock
reset  input  1  synchronous, active-high reset
symbol_in  input  10  aligned symbol; [9:4]=abcdei, [3:0]=fghj; bit 9 is the first bit received
symbol_valid  input  1  symbol_in qualifier (aligner data_valid)
align_valid  input  1  aligner lock indication
data_out  output  8  decoded byte; [7:5]=HGF, [4:0]=EDCBA
k_out  output  1  data_out is a control (K) character
data_out_valid  output  1  data_out/k_out/code_err/disp_err qualifier
code_err  output  1  symbol is not a legal 8b/10b codeword
disp_err  output  1  symbol disparity conflicts with running disparity
rd  output  1  current running disparity (0=RD-, 1=RD+)
unlock  output  1  one-cycle request to aligner to drop lock
err_count  output  CNT_W  saturating count of code_err|disp_err events since reset

Behaviour:
- Reset values: data_out=0, k_out=0, data_out_valid=0, code_err=0, disp_err=0, rd=0, unlock=0, err_count=0, state=WAIT_ALIGN, window counter=0, window error counter=0.
- Decode uses the standard 5b/6b and 3b/4b tables, including alternate D.x.A7 and all 12 K codes. Output is registered with 1-cycle latency: symbol at cycle N appears at N+1.
- Decoding is active only in RUN. data_out_valid = registered (symbol_valid && state==RUN).
- code_err:
  - Either sub-block is illegal (6b with disparity ±4/±6, e.g. 000000, 111111; 4b 0000/1111).
  - Or an illegal combination: K.28 6b with a non-K 4b; D.x.A7 used where the primary A7 is required; K.x.7 other than x in {23,27,28,29,30}.
  - On code_err: data_out=0, k_out=0, rd unchanged.
- disp_err (legal codeword only): a +2 sub-block under RD+, or a −2 sub-block under RD-, evaluated per sub-block sequentially (6b updates the intermediate RD before 4b is checked). rd is still updated from the symbol's own sub-block disparities.
- rd update: after the 6b sub-block, then the 4b sub-block. A non-neutral sub-block sets RD to its sign; a neutral one (incl. 000111/111000 and 0011/1100 cases) keeps RD.
- States:
  - WAIT_ALIGN: wait for align_valid=1, then go to RUN; rd, window counter and window error counter are cleared on entry to RUN.
  - RUN: normal decode.
    - align_valid=0 -> WAIT_ALIGN (no unlock).
    - Window error counter reaching ERR_THRESH -> assert unlock for exactly one cycle, go to HOLD.
  - HOLD: no decode; wait for align_valid=0, then WAIT_ALIGN. unlock is not re-asserted.
- Error window:
  - In RUN, each valid symbol increments the window counter.
  - When it reaches WINDOW it wraps to 0 and the window error counter clears in the same cycle. An error on that same symbol is counted into the new window.
  - An error counts once even if code_err and disp_err are both set.
- err_count increments on every flagged symbol in RUN and saturates at 2^CNT_W−1. It is cleared only by reset.
- Simultaneous threshold hit and align_valid falling: unlock pulses and the state goes to HOLD. HOLD then exits to WAIT_ALIGN on the next cycle.
- Reset mid-operation clears everything within one cycle. An in-flight symbol is discarded.

Test Plan:
- Reset, align_valid=1, symbol 0011111010 (K28.5 RD-) -> next cycle data_out=0xBC, k_out=1, data_out_valid=1, rd=1, no errors.
- From rd=1 send 1010101010 (D21.5) -> data_out=0xB5, k_out=0, rd stays 1; then 1100000101 (K28.5 RD+) -> 0xBC, k=1, rd=0.
- From rd=0 send K28.5 RD- twice -> second gives disp_err=1, code_err=0, data_out=0xBC, err_count=1.
- Send 0000000000 -> code_err=1, data_out=0, k_out=0, rd unchanged.
- WINDOW=8, ERR_THRESH=2: two code errors within 8 symbols -> unlock high exactly one cycle, state HOLD, no data_out_valid. Drop then raise align_valid -> decoding resumes with rd=0.
- WINDOW=8: one error at symbol 7, one at symbol 9 -> no unlock (window cleared at wrap); err_count=2.

Source files
------------

// File: rtl/m_phy_lane_10b8b_dec.sv
// Per-lane 8b/10b decoder with running-disparity tracking and windowed link-quality monitor.
// One-cycle registered output; requests re-alignment via a single unlock pulse on excessive errors.
module m_phy_lane_10b8b_dec #(
  parameter int unsigned WINDOW     = 256,
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [9:0]       i_symbol_in,
  input  logic             i_symbol_valid,
  input  logic             i_align_valid,
  output logic [7:0]       o_data_out,
  output logic             o_k_out,
  output logic             o_data_out_valid,
  output logic             o_code_err,
  output logic             o_disp_err,
  output logic             o_rd,
  output logic             o_unlock,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int unsigned WIN_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {S_WAIT_ALIGN, S_RUN, S_HOLD} state_t;

  // {legal, EDCBA}; both K.28 forms decode to 28
  function automatic logic [5:0] f_dec6(input logic [5:0] c);
    case (c)
      6'b100111, 6'b011000: f_dec6 = {1'b1, 5'd0};
      6'b011101, 6'b100010: f_dec6 = {1'b1, 5'd1};
      6'b101101, 6'b010010: f_dec6 = {1'b1, 5'd2};
      6'b110001:            f_dec6 = {1'b1, 5'd3};
      6'b110101, 6'b001010: f_dec6 = {1'b1, 5'd4};
      6'b101001:            f_dec6 = {1'b1, 5'd5};
      6'b011001:            f_dec6 = {1'b1, 5'd6};
      6'b111000, 6'b000111: f_dec6 = {1'b1, 5'd7};
      6'b111001, 6'b000110: f_dec6 = {1'b1, 5'd8};
      6'b100101:            f_dec6 = {1'b1, 5'd9};
      6'b010101:            f_dec6 = {1'b1, 5'd10};
      6'b110100:            f_dec6 = {1'b1, 5'd11};
      6'b001101:            f_dec6 = {1'b1, 5'd12};
      6'b101100:            f_dec6 = {1'b1, 5'd13};
      6'b011100:            f_dec6 = {1'b1, 5'd14};
      6'b010111, 6'b101000: f_dec6 = {1'b1, 5'd15};
      6'b011011, 6'b100100: f_dec6 = {1'b1, 5'd16};
      6'b100011:            f_dec6 = {1'b1, 5'd17};
      6'b010011:            f_dec6 = {1'b1, 5'd18};
      6'b110010:            f_dec6 = {1'b1, 5'd19};
      6'b001011:            f_dec6 = {1'b1, 5'd20};
      6'b101010:            f_dec6 = {1'b1, 5'd21};
      6'b011010:            f_dec6 = {1'b1, 5'd22};
      6'b111010, 6'b000101: f_dec6 = {1'b1, 5'd23};
      6'b110011, 6'b001100: f_dec6 = {1'b1, 5'd24};
      6'b100110:            f_dec6 = {1'b1, 5'd25};
      6'b010110:            f_dec6 = {1'b1, 5'd26};
      6'b110110, 6'b001001: f_dec6 = {1'b1, 5'd27};
      6'b001110, 6'b001111, 6'b110000: f_dec6 = {1'b1, 5'd28};
      6'b101110, 6'b010001: f_dec6 = {1'b1, 5'd29};
      6'b011110, 6'b100001: f_dec6 = {1'b1, 5'd30};
      6'b101011, 6'b010100: f_dec6 = {1'b1, 5'd31};
      default:              f_dec6 = 6'd0;
    endcase
  endfunction

  // {legal, alt7, prim7, HGF}
  function automatic logic [5:0] f_dec4(input logic [3:0] c);
    case (c)
      4'b1011, 4'b0100: f_dec4 = {3'b100, 3'd0};
      4'b1001:          f_dec4 = {3'b100, 3'd1};
      4'b0101:          f_dec4 = {3'b100, 3'd2};
      4'b1100, 4'b0011: f_dec4 = {3'b100, 3'd3};
      4'b1101, 4'b0010: f_dec4 = {3'b100, 3'd4};
      4'b1010:          f_dec4 = {3'b100, 3'd5};
      4'b0110:          f_dec4 = {3'b100, 3'd6};
      4'b1110, 4'b0001: f_dec4 = {3'b101, 3'd7};
      4'b0111, 4'b1000: f_dec4 = {3'b110, 3'd7};
      default:          f_dec4 = 6'd0;
    endcase
  endfunction

  state_t             r_state, w_state_nx;
  logic [7:0]         r_data;
  logic               r_k, r_dout_vld, r_code_err, r_disp_err, r_rd, r_unlock;
  logic [CNT_W-1:0]   r_err_count;
  logic [WIN_W-1:0]   r_win_cnt, r_win_err;

  logic [5:0] w_c6;
  logic [3:0] w_c4, w_f4;
  logic [4:0] w_x;
  logic [2:0] w_y;
  logic       w_ok6, w_ok4, w_a7, w_p7, w_k28, w_kx7, w_da7;
  logic       w_code_err, w_disp_err, w_rd_mid, w_rd_new;
  logic       w_d6p, w_d6n, w_d4p, w_d4n;
  logic       w_dec, w_err, w_wrap, w_hit, w_enter_run;
  logic [WIN_W-1:0] w_win_cnt_nx, w_win_err_nx;

  assign w_c6  = i_symbol_in[9:4];
  assign w_c4  = i_symbol_in[3:0];
  assign w_k28 = (w_c6 == 6'b001111) || (w_c6 == 6'b110000);
  // The RD+ form of K.28 carries a complemented 3b/4b block
  assign w_f4  = (w_c6 == 6'b110000) ? ~w_c4 : w_c4;
  assign {w_ok6, w_x} = f_dec6(w_c6);
  assign {w_ok4, w_a7, w_p7, w_y} = f_dec4(w_f4);

  assign w_kx7 = w_a7 && ((w_x == 5'd23) || (w_x == 5'd27) || (w_x == 5'd29) || (w_x == 5'd30));
  assign w_da7 = w_a7 && ((((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20)) && (w_c4 == 4'b0111)) ||
                          (((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14)) && (w_c4 == 4'b1000)));
  assign w_code_err = !w_ok6 || !w_ok4 || (w_k28 && w_p7) || (w_a7 && !w_k28 && !w_kx7 && !w_da7);

  assign w_d6p = ($countones(w_c6) == 4);
  assign w_d6n = ($countones(w_c6) == 2);
  assign w_d4p = ($countones(w_c4) == 3);
  assign w_d4n = ($countones(w_c4) == 1);
  assign w_rd_mid = w_d6p ? 1'b1 : (w_d6n ? 1'b0 : r_rd);
  assign w_rd_new = w_d4p ? 1'b1 : (w_d4n ? 1'b0 : w_rd_mid);
  assign w_disp_err = !w_code_err && ((w_d6p && r_rd) || (w_d6n && !r_rd) ||
                                      (w_d4p && w_rd_mid) || (w_d4n && !w_rd_mid));

  assign w_dec       = i_symbol_valid && (r_state == S_RUN);
  assign w_err       = w_dec && (w_code_err || w_disp_err);
  assign w_enter_run = (r_state == S_WAIT_ALIGN) && i_align_valid;
  // The wrapping symbol's own error lands in the fresh window
  assign w_wrap       = (r_win_cnt == WIN_W'(WINDOW - 1));
  assign w_win_cnt_nx = w_wrap ? '0 : r_win_cnt + 1'b1;
  assign w_win_err_nx = (w_wrap ? '0 : r_win_err) + WIN_W'(w_err);
  assign w_hit        = w_err && (w_win_err_nx >= WIN_W'(ERR_THRESH));

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_WAIT_ALIGN: if (i_align_valid) w_state_nx = S_RUN;
      S_RUN: begin
        if (w_hit)               w_state_nx = S_HOLD;
        else if (!i_align_valid) w_state_nx = S_WAIT_ALIGN;
      end
      S_HOLD:       if (!i_align_valid) w_state_nx = S_WAIT_ALIGN;
      default:      w_state_nx = S_WAIT_ALIGN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_WAIT_ALIGN;
    else         r_state <= w_state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data      <= '0;
      r_k         <= 1'b0;
      r_dout_vld  <= 1'b0;
      r_code_err  <= 1'b0;
      r_disp_err  <= 1'b0;
      r_rd        <= 1'b0;
      r_unlock    <= 1'b0;
      r_err_count <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
    end else begin
      r_dout_vld <= w_dec;
      r_unlock   <= w_hit;
      if (w_dec) begin
        r_data     <= w_code_err ? 8'h00 : {w_y, w_x};
        r_k        <= !w_code_err && (w_k28 || w_kx7);
        r_code_err <= w_code_err;
        r_disp_err <= w_disp_err;
        if (!w_code_err) r_rd <= w_rd_new;
        r_win_cnt  <= w_win_cnt_nx;
        r_win_err  <= w_win_err_nx;
        if (w_err && (r_err_count != {CNT_W{1'b1}})) r_err_count <= r_err_count + 1'b1;
      end else if (w_enter_run) begin
        r_rd      <= 1'b0;
        r_win_cnt <= '0;
        r_win_err <= '0;
      end
    end
  end

  assign o_data_out       = r_data;
  assign o_k_out          = r_k;
  assign o_data_out_valid = r_dout_vld;
  assign o_code_err       = r_code_err;
  assign o_disp_err       = r_disp_err;
  assign o_rd             = r_rd;
  assign o_unlock         = r_unlock;
  assign o_err_count      = r_err_count;

endmodule

// File: tb/tb_m_phy_lane_10b8b_dec.sv
// Directed scoreboard bench for m_phy_lane_10b8b_dec (WINDOW=8, ERR_THRESH=2, 2-bit error counter).
module tb_m_phy_lane_10b8b_dec;
  localparam int CNT_W = 2;

  localparam logic [9:0] K28P   = 10'b0011111010;
  localparam logic [9:0] K28N   = 10'b1100000101;
  localparam logic [9:0] D215   = 10'b1010101010;
  localparam logic [9:0] D17A7  = 10'b1000110111;
  localparam logic [9:0] K237N  = 10'b0001010111;
  localparam logic [9:0] D000   = 10'b1001110100;
  localparam logic [9:0] BAD0   = 10'b0000000000;
  localparam logic [9:0] BAD4   = 10'b1010101111;
  localparam logic [9:0] K28P7  = 10'b0011110001;
  localparam logic [9:0] KX7BAD = 10'b1010010111;
  localparam logic [9:0] A7MIS  = 10'b1000111000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [9:0]       symbol_in = '0;
  logic             symbol_valid = 1'b0;
  logic             align_valid = 1'b0;
  logic [7:0]       data_out;
  logic             k_out, data_out_valid, code_err, disp_err, rd, unlock;
  logic [CNT_W-1:0] err_count;

  always #5 clk = ~clk;

  m_phy_lane_10b8b_dec #(.WINDOW(8), .ERR_THRESH(2), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_reset(reset), .i_symbol_in(symbol_in), .i_symbol_valid(symbol_valid),
    .i_align_valid(align_valid), .o_data_out(data_out), .o_k_out(k_out),
    .o_data_out_valid(data_out_valid), .o_code_err(code_err), .o_disp_err(disp_err),
    .o_rd(rd), .o_unlock(unlock), .o_err_count(err_count)
  );

  typedef struct packed {
    logic             vld;
    logic [7:0]       dat;
    logic             k, ce, de, rd, unl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic exp_t ex(input logic v, input logic [7:0] d, input logic k, input logic ce,
                              input logic de, input logic r, input logic u, input int c);
    exp_t t;
    t.vld = v; t.dat = d; t.k = k; t.ce = ce; t.de = de; t.rd = r; t.unl = u;
    t.cnt = CNT_W'(c);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (step %0d)", tag, obs, exp, n_chk);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    e = sb.pop_front();
    chk("data_out_valid", 16'(data_out_valid), 16'(e.vld));
    chk("rd", 16'(rd), 16'(e.rd));
    chk("unlock", 16'(unlock), 16'(e.unl));
    chk("err_count", 16'(err_count), 16'(e.cnt));
    if (e.vld) begin
      chk("data_out", 16'(data_out), 16'(e.dat));
      chk("k_out", 16'(k_out), 16'(e.k));
      chk("code_err", 16'(code_err), 16'(e.ce));
      chk("disp_err", 16'(disp_err), 16'(e.de));
    end
  endtask

  // Outputs are sampled on the falling edge; each step's expectation is compared one cycle later
  task automatic step(input logic rst, input logic av, input logic sv, input logic [9:0] sym, input exp_t e);
    @(negedge clk);
    if (sb.size() != 0) compare_head();
    reset        = rst;
    align_valid  = av;
    symbol_valid = sv;
    symbol_in    = sym;
    sb.push_back(e);
  endtask

  initial begin
    // reset, lock, basic decode and running disparity
    step(1, 0, 0, '0,    ex(0, 8'h00, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, '0,    ex(0, 8'h00, 0, 0, 0, 0, 0, 0));
    step(0, 1, 1, K28P,  ex(1, 8'hBC, 1, 0, 0, 1, 0, 0));
    step(0, 1, 1, D215,  ex(1, 8'hB5, 0, 0, 0, 1, 0, 0));
    step(0, 1, 1, K28N,  ex(1, 8'hBC, 1, 0, 0, 0, 0, 0));
    step(0, 1, 1, D17A7, ex(1, 8'hF1, 0, 0, 0, 1, 0, 0));
    step(0, 1, 1, K237N, ex(1, 8'hF7, 1, 0, 0, 1, 0, 0));
    step(0, 1, 1, K28N,  ex(1, 8'hBC, 1, 0, 0, 0, 0, 0));
    step(0, 1, 1, D000,  ex(1, 8'h00, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, '0,    ex(0, 8'h00, 0, 0, 0, 0, 0, 0));
    // losing lock in RUN: last symbol still decoded, then nothing
    step(0, 0, 1, D215,  ex(1, 8'hB5, 0, 0, 0, 0, 0, 0));
    step(0, 0, 1, D215,  ex(0, 8'h00, 0, 0, 0, 0, 0, 0));
    step(0, 1, 1, K28P,  ex(0, 8'h00, 0, 0, 0, 0, 0, 0));
    // reset mid-stream discards the in-flight symbol
    step(1, 1, 1, K28P,  ex(0, 8'h00, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, '0,    ex(0, 8'h00, 0, 0, 0, 0, 0, 0));
    step(0, 1, 1, K28P,  ex(1, 8'hBC, 1, 0, 0, 1, 0, 0));
    step(0, 1, 1, K28P,  ex(1, 8'hBC, 1, 0, 1, 1, 0, 1));
    step(0, 1, 1, BAD0,  ex(1, 8'h00, 0, 1, 0, 1, 1, 2));
    // HOLD ignores symbols until lock drops; rd clears on re-entry to RUN
    step(0, 1, 1, K28N,  ex(0, 8'h00, 0, 0, 0, 1, 0, 2));
    step(0, 1, 1, K28N,  ex(0, 8'h00, 0, 0, 0, 1, 0, 2));
    step(0, 0, 0, '0,    ex(0, 8'h00, 0, 0, 0, 1, 0, 2));
    step(0, 1, 0, '0,    ex(0, 8'h00, 0, 0, 0, 0, 0, 2));
    // window of 8: errors on symbols 7 and 9 straddle the wrap, 10 trips the threshold
    step(0, 1, 1, K28P,  ex(1, 8'hBC, 1, 0, 0, 1, 0, 2));
    step(0, 1, 1, D215,  ex(1, 8'hB5, 0, 0, 0, 1, 0, 2));
    step(0, 1, 1, D215,  ex(1, 8'hB5, 0, 0, 0, 1, 0, 2));
    step(0, 1, 0, '0,    ex(0, 8'h00, 0, 0, 0, 1, 0, 2));
    step(0, 1, 1, D215,  ex(1, 8'hB5, 0, 0, 0, 1, 0, 2));
    step(0, 1, 1, D215,  ex(1, 8'hB5, 0, 0, 0, 1, 0, 2));
    step(0, 1, 1, D215,  ex(1, 8'hB5, 0, 0, 0, 1, 0, 2));
    step(0, 1, 1, BAD4,  ex(1, 8'h00, 0, 1, 0, 1, 0, 3));
    step(0, 1, 1, D215,  ex(1, 8'hB5, 0, 0, 0, 1, 0, 3));
    step(0, 1, 1, K28P7, ex(1, 8'h00, 0, 1, 0, 1, 0, 3));
    step(0, 1, 1, KX7BAD, ex(1, 8'h00, 0, 1, 0, 1, 1, 3));
    step(0, 1, 1, D215,  ex(0, 8'h00, 0, 0, 0, 1, 0, 3));
    // threshold hit coincident with lock loss, misplaced alternate-7
    step(1, 0, 0, '0,    ex(0, 8'h00, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, '0,    ex(0, 8'h00, 0, 0, 0, 0, 0, 0));
    step(0, 1, 1, K28P,  ex(1, 8'hBC, 1, 0, 0, 1, 0, 0));
    step(0, 1, 1, A7MIS, ex(1, 8'h00, 0, 1, 0, 1, 0, 1));
    step(0, 0, 1, BAD0,  ex(1, 8'h00, 0, 1, 0, 1, 1, 2));
    step(0, 0, 0, '0,    ex(0, 8'h00, 0, 0, 0, 1, 0, 2));
    step(0, 1, 0, '0,    ex(0, 8'h00, 0, 0, 0, 0, 0, 2));
    step(0, 1, 1, K28P,  ex(1, 8'hBC, 1, 0, 0, 1, 0, 2));
    step(0, 1, 0, '0,    ex(0, 8'h00, 0, 0, 0, 1, 0, 2));
    @(negedge clk);
    while (sb.size() != 0) compare_head();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
